// File: rtl/insfetch.sv
// insfetch: instruction fetch unit with a single outstanding icache request,
// a one-entry hold buffer for downstream back-pressure, static JAL prediction
// and flush/redirect from the ROB.
// Optional feature: define INSFETCH_BHT_EN to add a 64-entry table of 2-bit
// saturating counters for branch direction prediction (indexed by pc[7:2]).
// Without it, conditional branches are always predicted not-taken.
module insfetch (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_valid,
    input  logic [31:0] ic_ins,
    input  logic        f_stall,
    output logic        is_ins,
    output logic [31:0] ins_addr,
    output logic [31:0] ins,
    output logic        pred_jmp,
    input  logic        rob_clear,
    input  logic [31:0] rob_new_pc,
    input  logic        br_upd,
    input  logic [31:0] br_upd_pc,
    input  logic        br_upd_taken
);

    localparam int unsigned XLEN      = 32;
    localparam int unsigned OPC_W     = 7;
    localparam int unsigned BHT_IDX_W = 6;
    localparam int unsigned BHT_DEPTH = 64;
    localparam int unsigned CTR_W     = 2;

    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [XLEN-1:0]  INS_BYTES = 32'd4;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] hold_ins;

    logic [XLEN-1:0] cand_ins_c;
    logic [XLEN-1:0] jal_imm_c;
    logic [XLEN-1:0] br_imm_c;
    logic [XLEN-1:0] next_pc_c;
    logic            pred_c;
    logic            br_taken_c;

`ifdef INSFETCH_BHT_EN
    logic [CTR_W-1:0]     bht [BHT_DEPTH];
    logic [BHT_IDX_W-1:0] rd_idx_c;
    logic [BHT_IDX_W-1:0] wr_idx_c;
    logic                 unused_upd_bits_c;

    assign rd_idx_c          = pc[7:2];
    assign wr_idx_c          = br_upd_pc[7:2];
    assign br_taken_c        = bht[rd_idx_c][1];
    assign unused_upd_bits_c = ^{br_upd_pc[31:8], br_upd_pc[1:0]};

    // Branch history counters; an issue in the same cycle reads the old value
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht[BHT_IDX_W'(i)] <= 2'b01;
            end
        end else if (rdy_in && br_upd) begin
            if (br_upd_taken) begin
                if (bht[wr_idx_c] != 2'b11) begin
                    bht[wr_idx_c] <= bht[wr_idx_c] + 2'd1;
                end
            end else begin
                if (bht[wr_idx_c] != 2'b00) begin
                    bht[wr_idx_c] <= bht[wr_idx_c] - 2'd1;
                end
            end
        end
    end
`else
    logic unused_upd_c;

    assign br_taken_c   = 1'b0;
    assign unused_upd_c = ^{br_upd, br_upd_pc, br_upd_taken};
`endif

    // Decode the instruction that could issue this cycle and predict its successor
    always_comb begin
        cand_ins_c = (state == S_HOLD) ? hold_ins : ic_ins;
        jal_imm_c  = {{11{cand_ins_c[31]}}, cand_ins_c[31], cand_ins_c[19:12],
                      cand_ins_c[20], cand_ins_c[30:21], 1'b0};
        br_imm_c   = {{19{cand_ins_c[31]}}, cand_ins_c[31], cand_ins_c[7],
                      cand_ins_c[30:25], cand_ins_c[11:8], 1'b0};
        next_pc_c  = pc + INS_BYTES;
        pred_c     = 1'b0;
        if (cand_ins_c[OPC_W-1:0] == OP_JAL) begin
            next_pc_c = pc + jal_imm_c;
            pred_c    = 1'b1;
        end else if ((cand_ins_c[OPC_W-1:0] == OP_BRANCH) && br_taken_c) begin
            next_pc_c = pc + br_imm_c;
            pred_c    = 1'b1;
        end
    end

    // Fetch FSM with registered icache and decode-side outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= S_FETCH;
            pc       <= '0;
            hold_ins <= '0;
            ic_req   <= 1'b0;
            ic_addr  <= '0;
            is_ins   <= 1'b0;
            ins      <= '0;
            ins_addr <= '0;
            pred_jmp <= 1'b0;
        end else if (rdy_in) begin
            is_ins <= 1'b0;
            if (rob_clear) begin
                // Redirect wins; an unanswered request must still be drained
                pc <= rob_new_pc;
                if (((state == S_WAIT) || (state == S_DISCARD)) && !ic_valid) begin
                    state <= S_DISCARD;
                end else begin
                    state  <= S_FETCH;
                    ic_req <= 1'b0;
                end
            end else begin
                unique case (state)
                    S_FETCH: begin
                        ic_req  <= 1'b1;
                        ic_addr <= pc;
                        state   <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (ic_valid) begin
                            ic_req <= 1'b0;
                            if (f_stall) begin
                                hold_ins <= ic_ins;
                                state    <= S_HOLD;
                            end else begin
                                is_ins   <= 1'b1;
                                ins      <= cand_ins_c;
                                ins_addr <= pc;
                                pred_jmp <= pred_c;
                                pc       <= next_pc_c;
                                state    <= S_FETCH;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!f_stall) begin
                            is_ins   <= 1'b1;
                            ins      <= cand_ins_c;
                            ins_addr <= pc;
                            pred_jmp <= pred_c;
                            pc       <= next_pc_c;
                            state    <= S_FETCH;
                        end
                    end
                    S_DISCARD: begin
                        if (ic_valid) begin
                            ic_req <= 1'b0;
                            state  <= S_FETCH;
                        end
                    end
                    default: begin
                        state <= S_FETCH;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_insfetch.sv
// tb_insfetch: directed scenarios plus randomized traffic for insfetch,
// checked every cycle against a transaction-level reference model.
// Build with or without INSFETCH_BHT_EN to match the DUT configuration.
module tb_insfetch;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_ins;
    logic        f_stall;
    logic        is_ins;
    logic [31:0] ins_addr;
    logic [31:0] ins;
    logic        pred_jmp;
    logic        rob_clear;
    logic [31:0] rob_new_pc;
    logic        br_upd;
    logic [31:0] br_upd_pc;
    logic        br_upd_taken;

    int n_cmp = 0;
    int n_err = 0;

    insfetch dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .ic_req       (ic_req),
        .ic_addr      (ic_addr),
        .ic_valid     (ic_valid),
        .ic_ins       (ic_ins),
        .f_stall      (f_stall),
        .is_ins       (is_ins),
        .ins_addr     (ins_addr),
        .ins          (ins),
        .pred_jmp     (pred_jmp),
        .rob_clear    (rob_clear),
        .rob_new_pc   (rob_new_pc),
        .br_upd       (br_upd),
        .br_upd_pc    (br_upd_pc),
        .br_upd_taken (br_upd_taken)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_live = 1'b0;
    bit          m_out;      // a request is in flight at the icache
    bit          m_drop;     // the in-flight response belongs to a flushed path
    bit          m_held;     // a fetched word is waiting for downstream space
    logic [31:0] m_hword;
    logic [31:0] m_pc;
    int          bht [64];
    logic        e_req, e_is, e_pred;
    logic [31:0] e_addr, e_ins, e_iaddr;

    function automatic bit bht_taken(input logic [31:0] pc);
        logic [5:0] idx;
        idx = pc[7:2];
`ifdef INSFETCH_BHT_EN
        return bht[idx] >= 2;
`else
        return (idx == 6'd0) && 1'b0;
`endif
    endfunction

    // Successor address and prediction from the ISA encoding rules
    task automatic predict(input logic [31:0] pc, input logic [31:0] w,
                           output logic [31:0] npc, output logic taken);
        logic [20:0] j;
        logic [12:0] b;
        int          off;
        npc   = pc + 32'd4;
        taken = 1'b0;
        if (w[6:0] == 7'b1101111) begin
            j     = {w[31], w[19:12], w[20], w[30:21], 1'b0};
            off   = w[31] ? int'(j) - (1 << 21) : int'(j);
            npc   = pc + 32'(off);
            taken = 1'b1;
        end else if (w[6:0] == 7'b1100011 && bht_taken(pc)) begin
            b     = {w[31], w[7], w[30:25], w[11:8], 1'b0};
            off   = w[31] ? int'(b) - (1 << 13) : int'(b);
            npc   = pc + 32'(off);
            taken = 1'b1;
        end
    endtask

    task automatic model_issue(input logic [31:0] w);
        logic [31:0] npc;
        logic        tk;
        predict(m_pc, w, npc, tk);
        e_is    = 1'b1;
        e_ins   = w;
        e_iaddr = m_pc;
        e_pred  = tk;
        m_pc    = npc;
    endtask

    // Advance the model on each edge using only the inputs the bench applied
    always @(posedge clk_in) begin
        if (rst_in) begin
            m_live = 1'b1; m_out = 1'b0; m_drop = 1'b0; m_held = 1'b0;
            m_pc = 32'd0; m_hword = 32'd0;
            e_req = 1'b0; e_addr = 32'd0; e_is = 1'b0; e_pred = 1'b0;
            e_ins = 32'd0; e_iaddr = 32'd0;
            for (int i = 0; i < 64; i++) bht[i] = 1;
        end else if (m_live && rdy_in) begin
            e_is = 1'b0;
            if (rob_clear) begin
                m_pc   = rob_new_pc;
                m_held = 1'b0;
                if (m_out && !ic_valid) m_drop = 1'b1;
                else begin
                    m_out = 1'b0; m_drop = 1'b0; e_req = 1'b0;
                end
            end else if (m_out) begin
                if (ic_valid) begin
                    m_out = 1'b0;
                    e_req = 1'b0;
                    if (m_drop) m_drop = 1'b0;
                    else if (f_stall) begin
                        m_held  = 1'b1;
                        m_hword = ic_ins;
                    end else model_issue(ic_ins);
                end
            end else if (m_held) begin
                if (!f_stall) begin
                    model_issue(m_hword);
                    m_held = 1'b0;
                end
            end else begin
                e_req  = 1'b1;
                e_addr = m_pc;
                m_out  = 1'b1;
            end
`ifdef INSFETCH_BHT_EN
            if (br_upd) begin
                if (br_upd_taken) bht[br_upd_pc[7:2]] = (bht[br_upd_pc[7:2]] < 3) ? bht[br_upd_pc[7:2]] + 1 : 3;
                else              bht[br_upd_pc[7:2]] = (bht[br_upd_pc[7:2]] > 0) ? bht[br_upd_pc[7:2]] - 1 : 0;
            end
`endif
        end
    end

    // Compare DUT outputs with the model on the falling edge
    always @(negedge clk_in) begin
        if (m_live) begin
            chk("is_ins", 32'(is_ins), 32'(e_is));
            chk("ic_req", 32'(ic_req), 32'(e_req));
            if (e_req) chk("ic_addr", ic_addr, e_addr);
            chk("ins", ins, e_ins);
            chk("ins_addr", ins_addr, e_iaddr);
            chk("pred_jmp", 32'(pred_jmp), 32'(e_pred));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 4))
            0:       w[6:0] = 7'b1101111;
            1, 2:    w[6:0] = 7'b1100011;
            3:       w[6:0] = 7'b1100111;
            default: w[6:0] = 7'b0010011;
        endcase
        return w;
    endfunction

    task automatic cyc();
        @(negedge clk_in);
    endtask

    // Flush to a new PC from WAIT and drain the stale response
    task automatic redirect(input logic [31:0] npc);
        rob_clear = 1'b1; rob_new_pc = npc;
        cyc();
        rob_clear = 1'b0; ic_valid = 1'b1; ic_ins = 32'h0000_0013;
        cyc();
        ic_valid = 1'b0;
        cyc();
        chk("redir_addr", ic_addr, npc);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; ic_valid = 1'b0; ic_ins = 32'd0;
        f_stall = 1'b0; rob_clear = 1'b0; rob_new_pc = 32'd0;
        br_upd = 1'b0; br_upd_pc = 32'd0; br_upd_taken = 1'b0;
        repeat (2) cyc();
        chk("rst_is_ins", 32'(is_ins), 32'd0);
        chk("rst_ic_req", 32'(ic_req), 32'd0);
        chk("rst_ins", ins, 32'd0);
        chk("rst_ins_addr", ins_addr, 32'd0);
        chk("rst_pred", 32'(pred_jmp), 32'd0);
        rst_in = 1'b0;

        // First fetch at PC 0, plain ALU op
        cyc();
        chk("f0_req", 32'(ic_req), 32'd1);
        chk("f0_addr", ic_addr, 32'd0);
        ic_valid = 1'b1; ic_ins = 32'h0000_0013;
        cyc();
        ic_valid = 1'b0;
        chk("f0_is", 32'(is_ins), 32'd1);
        chk("f0_iaddr", ins_addr, 32'd0);
        chk("f0_pred", 32'(pred_jmp), 32'd0);
        cyc();
        chk("f0_next", ic_addr, 32'h4);

        // Flush during WAIT, stale response arrives two cycles later
        rob_clear = 1'b1; rob_new_pc = 32'h100;
        cyc();
        rob_clear = 1'b0;
        chk("dc_req", 32'(ic_req), 32'd1);
        chk("dc_oldaddr", ic_addr, 32'h4);
        cyc();
        ic_valid = 1'b1; ic_ins = 32'h0000_0013;
        cyc();
        ic_valid = 1'b0;
        chk("dc_no_issue", 32'(is_ins), 32'd0);
        chk("dc_req_drop", 32'(ic_req), 32'd0);
        cyc();
        chk("dc_next", ic_addr, 32'h100);

        // JAL at 0x10 jumps to 0x18
        redirect(32'h10);
        ic_valid = 1'b1; ic_ins = 32'h0080_006F;
        cyc();
        ic_valid = 1'b0;
        chk("jal_is", 32'(is_ins), 32'd1);
        chk("jal_pred", 32'(pred_jmp), 32'd1);
        chk("jal_iaddr", ins_addr, 32'h10);
        cyc();
        chk("jal_next", ic_addr, 32'h18);

        // Downstream stall for three cycles, then one issue
        f_stall = 1'b1; ic_valid = 1'b1; ic_ins = 32'h00A0_0093;
        for (int i = 0; i < 3; i++) begin
            cyc();
            ic_valid = 1'b0;
            chk("stall_no_issue", 32'(is_ins), 32'd0);
        end
        f_stall = 1'b0;
        cyc();
        chk("stall_is", 32'(is_ins), 32'd1);
        chk("stall_ins", ins, 32'h00A0_0093);
        chk("stall_iaddr", ins_addr, 32'h18);
        cyc();
        chk("stall_next", ic_addr, 32'h1C);

        // Frozen while HOLD with rdy low
        f_stall = 1'b1; ic_valid = 1'b1; ic_ins = 32'h0010_0113;
        cyc();
        ic_valid = 1'b0; rdy_in = 1'b0; f_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("frz_is", 32'(is_ins), 32'd0);
            chk("frz_ins", ins, 32'h00A0_0093);
        end
        rdy_in = 1'b1;
        cyc();
        chk("frz_issue", 32'(is_ins), 32'd1);
        chk("frz_ins_new", ins, 32'h0010_0113);
        chk("frz_iaddr", ins_addr, 32'h1C);

        // Train 0x20 taken twice, then beq +16 at 0x20
        br_upd = 1'b1; br_upd_pc = 32'h20; br_upd_taken = 1'b1;
        cyc();
        cyc();
        br_upd = 1'b0;
        chk("bht_addr", ic_addr, 32'h20);
        ic_valid = 1'b1; ic_ins = 32'h0000_0863;
        cyc();
        ic_valid = 1'b0;
        chk("bht_is", 32'(is_ins), 32'd1);
        chk("bht_iaddr", ins_addr, 32'h20);
`ifdef INSFETCH_BHT_EN
        chk("bht_pred", 32'(pred_jmp), 32'd1);
        cyc();
        chk("bht_next", ic_addr, 32'h30);
`else
        chk("bht_pred", 32'(pred_jmp), 32'd0);
        cyc();
        chk("bht_next", ic_addr, 32'h24);
`endif

        // Reset with a request in flight restarts cleanly at PC 0
        rst_in = 1'b1;
        cyc();
        rst_in = 1'b0;
        chk("rstmid_req", 32'(ic_req), 32'd0);
        cyc();
        chk("rstmid_req2", 32'(ic_req), 32'd1);
        chk("rstmid_addr", ic_addr, 32'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst_in       = ($urandom_range(0, 299) == 0);
            rdy_in       = ($urandom_range(0, 9) != 0);
            f_stall      = ($urandom_range(0, 9) < 3);
            rob_clear    = ($urandom_range(0, 24) == 0);
            rob_new_pc   = $urandom & 32'h0000_0FFC;
            br_upd       = ($urandom_range(0, 9) < 3);
            br_upd_pc    = $urandom & 32'h0000_00FC;
            br_upd_taken = 1'($urandom_range(0, 1));
            ic_valid     = ic_req && rdy_in && !rst_in && ($urandom_range(0, 9) < 4);
            ic_ins       = ic_valid ? rand_word() : $urandom;
            cyc();
        end
        rst_in = 1'b0; rdy_in = 1'b1; ic_valid = 1'b0;
        rob_clear = 1'b0; br_upd = 1'b0;
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
